// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor helper, frame size and
// the transmit FSM state type. The receive path uses the same codes and divisor.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Clock cycles per bit for a rate select; codes above 115200 alias to 115200.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0]  sel);
    case (sel)
      BAUD_9600:  return clk_freq / 9600;
      BAUD_19200: return clk_freq / 19200;
      BAUD_38400: return clk_freq / 38400;
      BAUD_57600: return clk_freq / 57600;
      default:    return clk_freq / 115200;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_tx_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count. Pushes while full and
// pops while empty are ignored; the head word is visible on dout without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: bytes are queued in a FIFO and serialised on
// tx at the rate chosen by baud_set, which is latched at the start of each frame.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  tx_state_t   state;
  logic [7:0]  shreg;
  logic [7:0]  head;
  logic [2:0]  bit_cnt;
  logic [31:0] div_cnt;
  logic [31:0] bit_last;
  logic        push;
  logic        pop;
  logic        bit_end;

  assign push    = wr_en & ~full;
  assign pop     = (state == IDLE) & ~empty;
  assign busy    = (state != IDLE);
  assign bit_end = (div_cnt == bit_last);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Sticky flag for writes that were dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  // Frame sequencer. tx_done is raised one cycle early so that, being
  // registered, it is high exactly during the last cycle of the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      bit_last <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shreg    <= head;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            bit_last <= baud_div(CLK_FREQ, baud_set) - 32'd1;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 32'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 32'd1;
            tx_done <= (div_cnt == bit_last - 32'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
